// File: rtl/aud_rec_writer.sv
// rtl/aud_rec_writer.sv - ADC sample recorder with optional decimation into external SRAM
module aud_rec_writer #(
  parameter int                 ADDR_W   = 20,
  parameter int                 DATA_W   = 16,
  parameter logic [ADDR_W-1:0]  MAX_ADDR = 20'hFFFFF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic [1:0]        i_decim,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic              i_adc_valid,
  input  logic [DATA_W-1:0] i_adc_data,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_data,
  output logic              o_sram_we,
  output logic              o_recording,
  output logic              o_done,
  output logic [ADDR_W:0]   o_len
);

  // Up to 8 samples are summed, so three guard bits keep the sum exact.
  localparam int ACC_W = DATA_W + 3;

  typedef enum logic [2:0] {S_IDLE, S_REC, S_WRITE, S_PAUSE, S_DONE} state_t;

  state_t                   r_state, w_next;
  logic [ADDR_W-1:0]        r_addr;
  logic [DATA_W-1:0]        r_data;
  logic [ADDR_W:0]          r_len;
  logic signed [ACC_W-1:0]  r_acc;
  logic [2:0]               r_cnt;
  logic [1:0]               r_decim;
  // A group that completes during the WRITE cycle is parked here and written
  // from the following REC cycle, so the write strobe never runs back to back.
  logic                     r_pend;
  logic [DATA_W-1:0]        r_pend_data;

  logic [1:0]               w_decim;
  logic [2:0]               w_cnt_last;
  logic                     w_last;
  logic signed [ACC_W-1:0]  w_sext;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_avg;
  logic                     w_at_max;
  logic                     w_unused;

  // Decimation factor is latched at the first sample of each group.
  assign w_decim  = (r_cnt == 3'd0) ? i_decim : r_decim;
  assign w_sext   = {{3{i_adc_data[DATA_W-1]}}, i_adc_data};
  assign w_sum    = r_acc + w_sext;
  assign w_avg    = w_sum >>> w_decim;
  assign w_last   = (r_cnt == w_cnt_last);
  assign w_at_max = (r_addr == MAX_ADDR);
  assign w_unused = &{1'b0, w_avg[ACC_W-1:DATA_W]};

  // Last counter value of a group for the active decimation factor.
  always_comb begin
    w_cnt_last = 3'd0;
    case (w_decim)
      2'd0: w_cnt_last = 3'd0;
      2'd1: w_cnt_last = 3'd1;
      2'd2: w_cnt_last = 3'd3;
      default: w_cnt_last = 3'd7;
    endcase
  end

  // Next-state logic; a pending or completing word outranks the control inputs in REC.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (i_start) w_next = S_REC;
      S_REC: begin
        if (r_pend || (i_adc_valid && w_last)) w_next = S_WRITE;
        else if (i_stop)                       w_next = S_IDLE;
        else if (i_pause)                      w_next = S_PAUSE;
      end
      S_WRITE: begin
        if (w_at_max)     w_next = S_DONE;
        else if (i_stop)  w_next = S_IDLE;
        else if (i_pause) w_next = S_PAUSE;
        else              w_next = S_REC;
      end
      S_PAUSE: begin
        if (i_stop)       w_next = S_IDLE;
        else if (i_start) w_next = S_REC;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Datapath: accumulation, write data/address and recorded length.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr      <= '0;
      r_data      <= '0;
      r_len       <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_decim     <= '0;
      r_pend      <= 1'b0;
      r_pend_data <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_addr <= i_start_addr;
            r_len  <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_pend <= 1'b0;
          end
        end
        S_REC, S_WRITE: begin
          if (i_adc_valid) begin
            r_decim <= w_decim;
            if (w_last) begin
              r_acc <= '0;
              r_cnt <= '0;
            end else begin
              r_acc <= w_sum;
              r_cnt <= r_cnt + 3'd1;
            end
          end
          if (r_state == S_WRITE) begin
            r_len <= r_len + 1'b1;
            if (!w_at_max) r_addr <= r_addr + 1'b1;
            if (i_adc_valid && w_last) begin
              r_pend      <= 1'b1;
              r_pend_data <= w_avg[DATA_W-1:0];
            end
          end else if (r_pend) begin
            r_data <= r_pend_data;
            r_pend <= i_adc_valid && w_last;
            if (i_adc_valid && w_last) r_pend_data <= w_avg[DATA_W-1:0];
          end else if (i_adc_valid && w_last) begin
            r_data <= w_avg[DATA_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign o_sram_addr = r_addr;
  assign o_sram_data = r_data;
  assign o_sram_we   = (r_state == S_WRITE);
  assign o_recording = (r_state == S_REC) || (r_state == S_WRITE);
  assign o_done      = (r_state == S_DONE);
  assign o_len       = r_len;

endmodule

// File: tb/tb_aud_rec_writer.sv
// tb/tb_aud_rec_writer.sv - scoreboard testbench for aud_rec_writer
module tb_aud_rec_writer;

  logic        clk = 1'b0;
  logic        rst, start, pause, stop, adc_valid;
  logic [1:0]  decim;
  logic [19:0] start_addr;
  logic [15:0] adc_data;
  logic [19:0] sram_addr;
  logic [15:0] sram_data;
  logic        sram_we, recording, done;
  logic [20:0] len;

  typedef struct {
    logic [19:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc = 0;
  logic prev_we = 1'b0;

  aud_rec_writer #(.ADDR_W(20), .DATA_W(16), .MAX_ADDR(20'h00103)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_pause(pause), .i_stop(stop),
    .i_decim(decim), .i_start_addr(start_addr), .i_adc_valid(adc_valid),
    .i_adc_data(adc_data), .o_sram_addr(sram_addr), .o_sram_data(sram_data),
    .o_sram_we(sram_we), .o_recording(recording), .o_done(done), .o_len(len)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Write monitor: pops the scoreboard on every strobe.
  always @(negedge clk) begin
    n_checks = n_checks + 1;
    if (sram_we && prev_we) begin
      n_errors = n_errors + 1;
      $display("FAIL we_consecutive at cycle %0d", cyc);
    end
    prev_we = sram_we;
    if (sram_we) begin
      n_checks = n_checks + 2;
      if (exp_q.size() == 0) begin
        n_errors = n_errors + 1;
        $display("FAIL unexpected_write addr=%h data=%h", sram_addr, sram_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if ({sram_addr, sram_data} !== {e.addr, e.data}) begin
          n_errors = n_errors + 1;
          $display("FAIL write_value got addr=%h data=%h want addr=%h data=%h",
                   sram_addr, sram_data, e.addr, e.data);
        end
        if (cyc !== e.cyc) begin
          n_errors = n_errors + 1;
          $display("FAIL write_latency got cycle %0d want %0d", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [19:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a; e.data = d; e.cyc = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic pulse(input logic [15:0] d);
    adc_valid = 1'b1; adc_data = d;
    tick(1);
    adc_valid = 1'b0;
  endtask

  task automatic do_start(input logic [19:0] a, input logic [1:0] dc);
    start = 1'b1; start_addr = a; decim = dc;
    tick(1);
    start = 1'b0; start_addr = 20'hABCDE;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; pause = 0; stop = 0; adc_valid = 0;
    decim = 0; start_addr = 0; adc_data = 0;
    tick(3);
    rst = 1'b0;
    tick(1);
    n_checks = n_checks + 1;
    if ({sram_addr, sram_data, sram_we, recording, done, len} !== '0) begin
      n_errors = n_errors + 1;
      $display("FAIL reset_outputs got addr=%h data=%h we=%b rec=%b done=%b len=%0d want all 0",
               sram_addr, sram_data, sram_we, recording, done, len);
    end
  endtask

  task automatic test_decim0();
    do_start(20'h00100, 2'd0);
    n_checks = n_checks + 1;
    if (recording !== 1'b1) begin
      n_errors = n_errors + 1;
      $display("FAIL decim0_recording got %b want 1", recording);
    end
    expect_wr(20'h00100, 16'h0010); pulse(16'h0010); tick(2);
    expect_wr(20'h00101, 16'hFFF0); pulse(16'hFFF0); tick(2);
    expect_wr(20'h00102, 16'h7FFF); pulse(16'h7FFF); tick(2);
    n_checks = n_checks + 2;
    if (len !== 21'd3) begin
      n_errors = n_errors + 1;
      $display("FAIL decim0_len got %0d want 3", len);
    end
    if (exp_q.size() !== 0) begin
      n_errors = n_errors + 1;
      $display("FAIL decim0_missing got %0d pending want 0", exp_q.size());
    end
    do_stop();
  endtask

  task automatic test_average();
    do_start(20'h00010, 2'd2);
    pulse(16'd4); tick(1); pulse(16'd5); tick(1); pulse(16'd6); tick(1);
    expect_wr(20'h00010, 16'h0005); pulse(16'd8); tick(2);
    pulse(16'hFFFF); tick(1); pulse(16'hFFFE); tick(1); pulse(16'hFFFE); tick(1);
    expect_wr(20'h00011, 16'hFFFE); pulse(16'hFFFE); tick(2);
    n_checks = n_checks + 2;
    if (len !== 21'd2) begin
      n_errors = n_errors + 1;
      $display("FAIL average_len got %0d want 2", len);
    end
    if (exp_q.size() !== 0) begin
      n_errors = n_errors + 1;
      $display("FAIL average_missing got %0d pending want 0", exp_q.size());
    end
    do_stop();
  endtask

  task automatic test_pause();
    do_start(20'h00020, 2'd1);
    pulse(16'd100);
    pause = 1'b1; tick(1);
    n_checks = n_checks + 1;
    if (recording !== 1'b0) begin
      n_errors = n_errors + 1;
      $display("FAIL pause_recording got %b want 0", recording);
    end
    for (int i = 0; i < 3; i++) begin
      pulse(16'h1234); tick(1);
    end
    pause = 1'b0; start = 1'b1; tick(1); start = 1'b0;
    expect_wr(20'h00020, 16'd200); pulse(16'd300); tick(2);
    n_checks = n_checks + 2;
    if (len !== 21'd1) begin
      n_errors = n_errors + 1;
      $display("FAIL pause_len got %0d want 1", len);
    end
    if (exp_q.size() !== 0) begin
      n_errors = n_errors + 1;
      $display("FAIL pause_missing got %0d pending want 0", exp_q.size());
    end
    do_stop();
  endtask

  task automatic test_max_addr();
    do_start(20'h00102, 2'd0);
    expect_wr(20'h00102, 16'hAAAA); pulse(16'hAAAA); tick(2);
    expect_wr(20'h00103, 16'h5555); pulse(16'h5555); tick(2);
    pulse(16'h1111); tick(2);
    n_checks = n_checks + 4;
    if (done !== 1'b1) begin
      n_errors = n_errors + 1;
      $display("FAIL max_done got %b want 1", done);
    end
    if (len !== 21'd2) begin
      n_errors = n_errors + 1;
      $display("FAIL max_len got %0d want 2", len);
    end
    if (sram_addr !== 20'h00103) begin
      n_errors = n_errors + 1;
      $display("FAIL max_addr_hold got %h want 00103", sram_addr);
    end
    if (recording !== 1'b0) begin
      n_errors = n_errors + 1;
      $display("FAIL max_recording got %b want 0", recording);
    end
  endtask

  task automatic test_stop_with_write();
    do_start(20'h00030, 2'd0);
    n_checks = n_checks + 1;
    if (done !== 1'b0) begin
      n_errors = n_errors + 1;
      $display("FAIL restart_done got %b want 0", done);
    end
    expect_wr(20'h00030, 16'hBEEF);
    stop = 1'b1; adc_valid = 1'b1; adc_data = 16'hBEEF;
    tick(1);
    adc_valid = 1'b0;
    tick(1);
    stop = 1'b0;
    tick(1);
    n_checks = n_checks + 3;
    if (recording !== 1'b0) begin
      n_errors = n_errors + 1;
      $display("FAIL stopwr_recording got %b want 0", recording);
    end
    if (len !== 21'd1) begin
      n_errors = n_errors + 1;
      $display("FAIL stopwr_len got %0d want 1", len);
    end
    if (exp_q.size() !== 0) begin
      n_errors = n_errors + 1;
      $display("FAIL stopwr_missing got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_in_write();
    do_start(20'h00040, 2'd0);
    expect_wr(20'h00040, 16'h0777);
    pulse(16'h0777);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_checks = n_checks + 1;
    if ({sram_addr, sram_data, sram_we, recording, done, len} !== '0) begin
      n_errors = n_errors + 1;
      $display("FAIL rstwr_outputs got addr=%h data=%h we=%b rec=%b done=%b len=%0d want all 0",
               sram_addr, sram_data, sram_we, recording, done, len);
    end
    tick(1);
  endtask

  task automatic test_all_controls();
    do_start(20'h00050, 2'd1);
    pulse(16'd7);
    stop = 1'b1; pause = 1'b1; start = 1'b1;
    tick(1);
    stop = 1'b0; pause = 1'b0; start = 1'b0;
    tick(2);
    n_checks = n_checks + 3;
    if (recording !== 1'b0 || done !== 1'b0) begin
      n_errors = n_errors + 1;
      $display("FAIL allctl_state got rec=%b done=%b want 0 0", recording, done);
    end
    if (len !== 21'd0) begin
      n_errors = n_errors + 1;
      $display("FAIL allctl_len got %0d want 0", len);
    end
    pulse(16'd9); tick(2);
    if (exp_q.size() !== 0) begin
      n_errors = n_errors + 1;
      $display("FAIL allctl_queue got %0d pending want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_decim0();
    test_average();
    test_pause();
    test_max_addr();
    test_stop_with_write();
    test_reset_in_write();
    test_all_controls();
    tick(3);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
